// File: rtl/vga_plot_scheduler_pkg.sv
// Shared constants, encodings and on-screen helper for the snake VGA plot scheduler.
package snake_vga_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  localparam logic [X_W-1:0]   XDIM      = 8'd10;
  localparam logic [Y_W-1:0]   YDIM      = 7'd10;
  localparam logic [X_W-1:0]   XSCREEN   = 8'd160;
  localparam logic [Y_W-1:0]   YSCREEN   = 7'd120;
  localparam logic [COL_W-1:0] BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    SRC_CLR   = 2'd0,
    SRC_TAIL  = 2'd1,
    SRC_HEAD  = 2'd2,
    SRC_APPLE = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Pixel coordinates arrive one bit wider than the port so off-screen sums are not aliased.
  function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
    return (px < {1'b0, XSCREEN}) && (py < {1'b0, YSCREEN});
  endfunction

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// Requester handshakes plus the vga_adapter pixel port owned by the scheduler.
interface vga_plot_scheduler_if;
  import snake_vga_pkg::*;

  logic             clr_req;
  logic             clr_ack;
  logic             tail_req;
  logic [X_W-1:0]   tail_x;
  logic [Y_W-1:0]   tail_y;
  logic             tail_ack;
  logic             head_req;
  logic [X_W-1:0]   head_x;
  logic [Y_W-1:0]   head_y;
  logic [COL_W-1:0] head_colour;
  logic             head_ack;
  logic             apple_req;
  logic [X_W-1:0]   apple_x;
  logic [Y_W-1:0]   apple_y;
  logic [COL_W-1:0] apple_colour;
  logic             apple_ack;
  logic             busy;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_plot;

  modport master (
    output clr_req, tail_req, tail_x, tail_y, head_req, head_x, head_y, head_colour,
           apple_req, apple_x, apple_y, apple_colour,
    input  clr_ack, tail_ack, head_ack, apple_ack, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  clr_req, tail_req, tail_x, tail_y, head_req, head_x, head_y, head_colour,
           apple_req, apple_x, apple_y, apple_colour,
    output clr_ack, tail_ack, head_ack, apple_ack, busy, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/vga_plot_scheduler_cell_scan_counter.sv
// Nested raster counter: cx runs fastest over w columns, cy over h rows; last marks (w-1, h-1).
module cell_scan_counter
  import snake_vga_pkg::*;
(
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           load,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);

  logic [X_W-1:0] cx_r;
  logic [Y_W-1:0] cy_r;

  // Counter state: cleared on load, steps in raster order while enabled.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cx_r <= 8'd0;
      cy_r <= 7'd0;
    end else if (load) begin
      cx_r <= 8'd0;
      cy_r <= 7'd0;
    end else if (en) begin
      if (cx_r == w - 8'd1) begin
        cx_r <= 8'd0;
        if (cy_r == h - 7'd1) begin
          cy_r <= 7'd0;
        end else begin
          cy_r <= cy_r + 7'd1;
        end
      end else begin
        cx_r <= cx_r + 8'd1;
      end
    end else begin
      cx_r <= cx_r;
      cy_r <= cy_r;
    end
  end

  assign cx   = cx_r;
  assign cy   = cy_r;
  assign last = (cx_r == w - 8'd1) && (cy_r == h - 7'd1);

endmodule

// File: rtl/vga_plot_scheduler.sv
// Fixed-priority block-draw scheduler owning the vga_adapter pixel port.
// Optional job counter output enabled by defining VGA_PLOT_SCHED_STATS_EN.
module vga_plot_scheduler
  import snake_vga_pkg::*;
(
  input  logic                Clock,
  input  logic                Resetn,
  vga_plot_scheduler_if.slave bus
`ifdef VGA_PLOT_SCHED_STATS_EN
  ,
  output logic [15:0]         job_count
`endif
);

  state_e           state_r, state_nxt_s;
  src_e             src_r, grant_src_s;
  logic             grant_s;
  logic [X_W-1:0]   grant_x_s, ox_r;
  logic [Y_W-1:0]   grant_y_s, oy_r;
  logic [COL_W-1:0] grant_col_s, col_r;
  logic [X_W-1:0]   w_s, cx_s;
  logic [Y_W-1:0]   h_s, cy_s;
  logic             last_s, scan_en_s;
  logic [X_W:0]     sum_x_s;
  logic [Y_W:0]     sum_y_s;

  logic [X_W-1:0]   vga_x_r;
  logic [Y_W-1:0]   vga_y_r;
  logic [COL_W-1:0] vga_colour_r;
  logic             vga_plot_r, busy_r;
  logic             clr_ack_r, tail_ack_r, head_ack_r, apple_ack_r;

  // FSM state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = grant_s ? SCAN : IDLE;
      SCAN:    state_nxt_s = last_s ? DONE : SCAN;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: priority grant in IDLE (tail ahead of head so a head re-entering the old tail cell lands last).
  always_comb begin
    grant_s     = 1'b0;
    grant_src_s = SRC_CLR;
    grant_x_s   = 8'd0;
    grant_y_s   = 7'd0;
    grant_col_s = BG_COLOUR;
    scan_en_s   = (state_r == SCAN);
    if (state_r == IDLE) begin
      if (bus.clr_req) begin
        grant_s     = 1'b1;
        grant_src_s = SRC_CLR;
      end else if (bus.tail_req) begin
        grant_s     = 1'b1;
        grant_src_s = SRC_TAIL;
        grant_x_s   = bus.tail_x;
        grant_y_s   = bus.tail_y;
      end else if (bus.head_req) begin
        grant_s     = 1'b1;
        grant_src_s = SRC_HEAD;
        grant_x_s   = bus.head_x;
        grant_y_s   = bus.head_y;
        grant_col_s = bus.head_colour;
      end else if (bus.apple_req) begin
        grant_s     = 1'b1;
        grant_src_s = SRC_APPLE;
        grant_x_s   = bus.apple_x;
        grant_y_s   = bus.apple_y;
        grant_col_s = bus.apple_colour;
      end else begin
        grant_s = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
    end
  end

  // Job descriptor latched on the grant edge; later input changes are ignored.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      src_r <= SRC_CLR;
      ox_r  <= 8'd0;
      oy_r  <= 7'd0;
      col_r <= 3'b000;
    end else if (grant_s) begin
      src_r <= grant_src_s;
      ox_r  <= grant_x_s;
      oy_r  <= grant_y_s;
      col_r <= grant_col_s;
    end else begin
      src_r <= src_r;
      ox_r  <= ox_r;
      oy_r  <= oy_r;
      col_r <= col_r;
    end
  end

  assign w_s = (src_r == SRC_CLR) ? XSCREEN : XDIM;
  assign h_s = (src_r == SRC_CLR) ? YSCREEN : YDIM;

  cell_scan_counter u_scan (
    .Clock  (Clock),
    .Resetn (Resetn),
    .load   (grant_s),
    .en     (scan_en_s),
    .w      (w_s),
    .h      (h_s),
    .cx     (cx_s),
    .cy     (cy_s),
    .last   (last_s)
  );

  assign sum_x_s = {1'b0, ox_r} + {1'b0, cx_s};
  assign sum_y_s = {1'b0, oy_r} + {1'b0, cy_s};

  // Registered pixel port; coordinates hold their last value outside SCAN.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vga_x_r      <= 8'd0;
      vga_y_r      <= 7'd0;
      vga_colour_r <= 3'b000;
      vga_plot_r   <= 1'b0;
    end else if (scan_en_s) begin
      vga_x_r      <= sum_x_s[X_W-1:0];
      vga_y_r      <= sum_y_s[Y_W-1:0];
      vga_colour_r <= col_r;
      vga_plot_r   <= on_screen(sum_x_s, sum_y_s);
    end else begin
      vga_x_r      <= vga_x_r;
      vga_y_r      <= vga_y_r;
      vga_colour_r <= vga_colour_r;
      vga_plot_r   <= 1'b0;
    end
  end

  // Completion pulses and busy flag.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      clr_ack_r   <= 1'b0;
      tail_ack_r  <= 1'b0;
      head_ack_r  <= 1'b0;
      apple_ack_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      clr_ack_r   <= (state_r == DONE) && (src_r == SRC_CLR);
      tail_ack_r  <= (state_r == DONE) && (src_r == SRC_TAIL);
      head_ack_r  <= (state_r == DONE) && (src_r == SRC_HEAD);
      apple_ack_r <= (state_r == DONE) && (src_r == SRC_APPLE);
      busy_r      <= (state_r != IDLE);
    end
  end

`ifdef VGA_PLOT_SCHED_STATS_EN
  logic [15:0] job_count_r;

  // Saturating count of completed jobs, stepped alongside each ack.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      job_count_r <= 16'd0;
    end else if ((state_r == DONE) && (job_count_r != 16'hFFFF)) begin
      job_count_r <= job_count_r + 16'd1;
    end else begin
      job_count_r <= job_count_r;
    end
  end

  assign job_count = job_count_r;
`endif

  assign bus.vga_x      = vga_x_r;
  assign bus.vga_y      = vga_y_r;
  assign bus.vga_colour = vga_colour_r;
  assign bus.vga_plot   = vga_plot_r;
  assign bus.busy       = busy_r;
  assign bus.clr_ack    = clr_ack_r;
  assign bus.tail_ack   = tail_ack_r;
  assign bus.head_ack   = head_ack_r;
  assign bus.apple_ack  = apple_ack_r;

endmodule

// File: doc/vga_plot_scheduler.md
Name: vga_plot_scheduler

Overview:
- Sole owner of the vga_adapter pixel port (x, y, colour, plot) in the snake game.
- Arbitrates among four block-draw requesters: screen clear, tail erase, head draw and apple draw.
- For each granted job it scans one XDIM x YDIM cell, or the whole screen for a clear, one pixel per clock.
- It replaces the ad hoc draw/erase FSM and the XC/YC counters in the top level.

Parameters:
- XDIM, 10, cell width in pixels.
- YDIM, 10, cell height in pixels.
- XSCREEN, 160, screen width in pixels.
- YSCREEN, 120, screen height in pixels.
- BG_COLOUR, 3'b000, colour used for clear and tail erase.

Ports:
- Clock  in  1  system clock (CLOCK_50 at top).
- Resetn  in  1  asynchronous active-low reset.
- clr_req  in  1  request a full-screen clear.
- clr_ack  out  1  one-cycle completion pulse for clear.
- tail_req  in  1  request erase of one cell.
- tail_x  in  8  erase cell origin x.
- tail_y  in  7  erase cell origin y.
- tail_ack  out  1  completion pulse for tail erase.
- head_req  in  1  request draw of one cell.
- head_x  in  8  head cell origin x.
- head_y  in  7  head cell origin y.
- head_colour  in  3  head colour.
- head_ack  out  1  completion pulse for head draw.
- apple_req  in  1  request apple draw.
- apple_x  in  8  apple cell origin x.
- apple_y  in  7  apple cell origin y.
- apple_colour  in  3  apple colour.
- apple_ack  out  1  completion pulse for apple draw.
- busy  out  1  high while a job is granted or being scanned.
- vga_x  out  8  pixel x to vga_adapter.
- vga_y  out  7  pixel y to vga_adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write strobe.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (Clock, Resetn).
  - Asserting Resetn low forces state IDLE and clears all outputs and internal counters to 0.
  - A job in flight is abandoned with no ack.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Fixed priority clr > tail > head > apple. Tail is ahead of head so that a head entering the old tail cell is drawn last.
  - On an edge where any req is high, the scheduler latches source id, origin (clear uses 0,0), colour (BG_COLOUR for clr/tail), clears the counters cx/cy, and goes to SCAN.
  - Input changes after the grant edge are ignored.
- SCAN:
  - Each cycle emits one registered pixel: vga_x = ox+cx, vga_y = oy+cy, sums truncated to port width.
  - Raster order, cx fastest. Pixel (0,0) appears in the first SCAN cycle.
  - Extent W x H: W = XDIM, H = YDIM for a cell; W = XSCREEN, H = YSCREEN for a clear.
  - After pixel (W-1, H-1) the state goes to DONE.
- Clipping: if ox+cx >= XSCREEN or oy+cy >= YSCREEN, computed at full width (9 bits / 8 bits), vga_plot is 0 for that cycle. The counter still advances and the cycle is still consumed.
- DONE:
  - The matching *_ack is high for exactly one cycle; busy is still high.
  - Next state is IDLE.
- Latency: the req-sampled edge k is followed by W*H plot cycles, then the ack cycle. A cell job (10x10) therefore takes 102 cycles from grant to return to IDLE; a clear takes 19202.
- busy is high from edge k+1 through the ack cycle inclusive.
- Handshake:
  - Req is level and is held until ack.
  - A req still high in the cycle after its ack is treated as a new job.
  - A req that drops before grant is lost; this is legal.
- Simultaneous requests: the lower-priority req waits with no ack. Starvation of apple is acceptable; the game issues at most one head and one tail per tick.
- When not scanning, vga_plot is 0 and vga_x/vga_y/vga_colour hold their last values.

Optional Feature:
- VGA_PLOT_SCHED_STATS_EN defined:
  - Adds output job_count[15:0], incremented on every ack and saturating at 16'hFFFF.
  - job_count resets to 0.
- VGA_PLOT_SCHED_STATS_EN undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package snake_vga_pkg holds:
  - XSCREEN, YSCREEN, XDIM, YDIM, BG_COLOUR;
  - X_W = 8, Y_W = 7, COL_W = 3;
  - source encoding SRC_CLR = 0, SRC_TAIL = 1, SRC_HEAD = 2, SRC_APPLE = 3.
- One natural sub-module, cell_scan_counter: nested cx/cy counter with load, enable, runtime W/H inputs and a last flag.

Test Plan:
- Reset/idle: release Resetn with no reqs → vga_plot = 0, busy = 0, all acks 0, all outputs 0.
- Head draw: head_req = 1 at (40, 50), colour 3'b010 → 100 plot cycles covering x 40..49 and y 50..59 in raster order, then head_ack for one cycle; total 102 cycles.
- Priority: tail_req (20, 30) and head_req (30, 30) raised in the same cycle → tail scanned first in BG_COLOUR with tail_ack; head is then granted on the next IDLE edge.
- Clipping: apple at (155, 115) → 100 scan cycles, only 25 with vga_plot = 1 (x 155..159, y 115..119), then apple_ack.
- Clear vs others: clr_req with head_req pending → 19200 scan cycles with colour 000, clr_ack, then the head job runs.
- Mid-job reset: assert Resetn low at scan cycle 37 of a head job → outputs 0 immediately, no head_ack; after release, a still-high head_req restarts from pixel (0,0).
